gray_to_binary_decoder: RTL and testbench
=========================================

// Module: gray_to_binary_decoder
// PURPOSE
//  Receive-side counterpart of the binary_to_gray encoder. Accepts a WIDTH-bit Gray
//  code word over a valid/ready handshake and decodes it serially, one bit per clock,
//  MSB first. Presents the binary result over a valid/ready output handshake.
//  Sits between Gray-coded sources (counters, pointers) and binary consumers.
// PARAMETERS
//  WIDTH  4  Gray/binary word width in bits; legal range 1..32.
// PORTS
//  i_clk       in   1      Single clock; all logic on the rising edge.
//  i_rst       in   1      Synchronous, active-high reset; takes priority over all handshakes.
//  i_gray      in   WIDTH  Gray code word; sampled only on acceptance.
//  i_valid     in   1      i_gray is valid.
//  o_ready     out  1      Decoder can accept a word; equals (state==IDLE).
//  o_binary    out  WIDTH  Decoded binary word.
//  o_valid     out  1      o_binary (and o_step_err) are valid.
//  i_ready     in   1      Downstream consumes o_binary.
//  o_step_err  out  1      Step-check flag; qualified by o_valid (see CONFIGURATION).
// BEHAVIOUR
//  Reset:
//   - state=IDLE; o_binary=0; o_valid=0; o_step_err=0; previous-word tracker invalid.
//   - o_ready=1 from the first cycle after reset deasserts.
//  Acceptance: i_valid & o_ready at a rising edge with i_rst low.
//  FSM states: IDLE, DECODE, DONE.
//   - IDLE: on acceptance, latch g_q=i_gray, bin_q[W-1]=i_gray[W-1], idx=W-2.
//     Next state is DECODE; if WIDTH==1, next state is DONE.
//   - DECODE: each cycle bin_q[idx]=bin_q[idx+1]^g_q[idx], then idx decrements.
//     After idx==0 is computed, next state is DONE.
//   - DONE: o_valid=1; o_binary=bin_q, held stable. On i_valid... ignored.
//     On i_ready high at an edge, next state is IDLE and o_valid drops.
//  Timing:
//   - Acceptance at the edge ending cycle N gives o_valid high from cycle N+WIDTH.
//   - o_ready is low from cycle N+1 until the cycle after the output handshake.
//   - Throughput: at most one word per WIDTH+1 cycles; no overlap of input and output.
//  Backpressure: while o_valid & ~i_ready, hold o_binary and o_step_err; keep o_ready=0.
//  i_gray and i_valid are don't-care outside IDLE; words offered there are not consumed.
//  Reset mid-operation: any in-flight word is discarded, no o_valid is produced,
//  and the state returns to reset values.
//  Arithmetic: binary[i] = XOR of gray[WIDTH-1:i]; no width growth; no wrap concerns.
// CONFIGURATION
//  Macro GRAY_STEP_CHECK_EN:
//   - Defined: keep the last accepted Gray word. On each acceptance, o_step_err for that
//     word = (popcount(i_gray ^ prev) != 1), registered and presented with o_valid.
//     Equal successive words are flagged. The first word after reset is never flagged.
//   - Undefined: o_step_err is tied to 0, there is no prev register, and the port remains
//     for a stable interface.
// STRUCTURE
//  Package gray_pkg:
//   - typedef enum for the FSM states {IDLE, DECODE, DONE}.
//   - localparam GRAY_W_DEFAULT=4.
//   - function gray2bin_ref(), the combinational model used by the bench scoreboard.
//  One sub-module, gray_step_checker: prev register, XOR, popcount==1 compare.
//   - Instantiated only under GRAY_STEP_CHECK_EN.
// TESTING
//  1 Reset: hold i_rst 3 cycles with i_valid=1, i_gray=4'b1000.
//    -> o_valid=0, o_binary=0, no acceptance; o_ready=1 after release.
//  2 Decode table: i_gray 0110->0100, 1000->1111, 1101->1001, 0000->0000.
//    Then full sweep 0..15 vs gray2bin_ref, with i_ready tied 1.
//  3 Latency: accept 4'b1101 at cycle N -> o_valid first high at N+4, o_binary=1001.
//    o_ready low in N+1..N+4 and high at N+5.
//  4 Backpressure: i_ready=0 for 5 cycles in DONE -> o_binary and o_valid stable, o_ready=0.
//    A new word offered is not consumed. Raise i_ready -> IDLE next cycle.
//  5 Reset mid-decode: assert i_rst at N+2 -> o_valid never rises, all outputs 0.
//    The next word decodes correctly.
//  6 With GRAY_STEP_CHECK_EN: feed 0000,0001,0011,0000,0000 -> o_step_err 0,0,0,1,1.
//    Without the macro, the same feed gives o_step_err all 0.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types and reference model for the serial Gray-to-binary decoder.
// Optional step checking is enabled by defining GRAY_STEP_CHECK_EN.
package gray_pkg;

  localparam int GRAY_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_e;

  // binary[i] is the XOR of all Gray bits at or above position i
  function automatic logic [31:0] gray2bin_ref(
    input logic [31:0] g
  );
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_step_checker.sv
// Flags accepted Gray words that differ from the previous one in other than one bit.
// Built only when GRAY_STEP_CHECK_EN is defined.
module gray_step_checker #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_accept,
  input  logic [WIDTH-1:0] i_gray,
  output logic             o_err
);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic             prev_vld_q, prev_vld_d;
  logic             err_q, err_d;

  always_comb begin
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    err_d      = err_q;
    if (i_accept) begin
      prev_d     = i_gray;
      prev_vld_d = 1'b1;
      err_d      = prev_vld_q &&
                   ($countones(i_gray ^ prev_q) != 1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      err_q      <= err_d;
    end
  end

  assign o_err = err_q;

endmodule

// File: rtl/gray_to_binary_decoder.sv
// Serial MSB-first Gray-to-binary decoder with valid/ready on both sides.
// Define GRAY_STEP_CHECK_EN to enable the single-bit-step checker.
module gray_to_binary_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_gray,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_binary,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_step_err
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_START =
    IDX_W'((WIDTH > 1) ? WIDTH - 2 : 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             accept;

  assign o_ready  = (state_q == IDLE);
  assign o_valid  = (state_q == DONE);
  assign o_binary = bin_q;
  assign accept   = i_valid & o_ready;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    bin_d   = bin_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          g_d              = i_gray;
          bin_d            = '0;
          bin_d[WIDTH-1]   = i_gray[WIDTH-1];
          idx_d            = IDX_START;
          state_d          = (WIDTH == 1) ? DONE : DECODE;
        end
      end
      DECODE: begin
        bin_d[idx_q] = bin_q[idx_q + IDX_W'(1)] ^ g_q[idx_q];
        idx_d        = idx_q - IDX_W'(1);
        if (idx_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      bin_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      bin_q   <= bin_d;
      idx_q   <= idx_d;
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  gray_step_checker #(
    .WIDTH(WIDTH)
  ) u_step_chk (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_accept(accept),
    .i_gray  (i_gray),
    .o_err   (o_step_err)
  );
`else
  // Port kept so both builds share one interface
  assign o_step_err = 1'b0;
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_gray_to_binary_decoder.sv
// Directed bench for gray_to_binary_decoder (WIDTH=4).
// Step-error expectations follow GRAY_STEP_CHECK_EN.
module tb_gray_to_binary_decoder;
  import gray_pkg::*;

  logic       i_clk;
  logic       i_rst;
  logic [3:0] i_gray;
  logic       i_valid;
  logic       o_ready;
  logic [3:0] o_binary;
  logic       o_valid;
  logic       i_ready;
  logic       o_step_err;

  int n_vec;
  int n_err;

  gray_to_binary_decoder #(
    .WIDTH(4)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_gray    (i_gray),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_binary  (o_binary),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_step_err(o_step_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic xfer(
    input  logic [3:0] g,
    input  logic [3:0] exp,
    input  string      tag,
    output logic       err
  );
    int k;
    i_ready = 1'b1;
    chk({tag, ":rdy"}, 32'(o_ready), 32'd1);
    i_gray  = g;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    k = 1;
    while (!o_valid && k < 20) begin
      step();
      k++;
    end
    chk({tag, ":lat"}, 32'(k), 32'd4);
    chk({tag, ":bin"}, 32'(o_binary), 32'(exp));
    err = o_step_err;
    step();
  endtask

  logic [31:0] ref_w;
  logic        e;
  logic [4:0]  errs;
  logic [4:0]  exp_errs;

  initial begin
    n_vec   = 0;
    n_err   = 0;
    i_rst   = 1'b1;
    i_valid = 1'b1;
    i_gray  = 4'b1000;
    i_ready = 1'b0;

    // 1: reset with a word offered
    repeat (3) step();
    chk("rst:valid", 32'(o_valid), 32'd0);
    chk("rst:bin", 32'(o_binary), 32'd0);
    chk("rst:serr", 32'(o_step_err), 32'd0);
    i_rst   = 1'b0;
    i_valid = 1'b0;
    step();
    chk("rel:ready", 32'(o_ready), 32'd1);
    chk("rel:valid", 32'(o_valid), 32'd0);

    // 2: table and sweep
    xfer(4'b0110, 4'b0100, "t0110", e);
    xfer(4'b1000, 4'b1111, "t1000", e);
    xfer(4'b1101, 4'b1001, "t1101", e);
    xfer(4'b0000, 4'b0000, "t0000", e);
    for (int v = 0; v < 16; v++) begin
      ref_w = gray2bin_ref(32'(v));
      xfer(4'(v), ref_w[3:0], $sformatf("sw%0d", v), e);
    end

    // 3: latency
    i_ready = 1'b1;
    i_gray  = 4'b1101;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("lat:rdy%0d", c), 32'(o_ready), 32'd0);
      chk($sformatf("lat:vld%0d", c), 32'(o_valid), 32'd0);
      step();
    end
    chk("lat:vld4", 32'(o_valid), 32'd1);
    chk("lat:rdy4", 32'(o_ready), 32'd0);
    chk("lat:bin4", 32'(o_binary), 32'h9);
    step();
    chk("lat:rdy5", 32'(o_ready), 32'd1);
    chk("lat:vld5", 32'(o_valid), 32'd0);

    // 4: backpressure with a competing word offered
    i_ready = 1'b0;
    i_gray  = 4'b0110;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    repeat (3) step();
    chk("bp:vld", 32'(o_valid), 32'd1);
    i_gray  = 4'b1111;
    i_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp:vld%0d", c), 32'(o_valid), 32'd1);
      chk($sformatf("bp:bin%0d", c), 32'(o_binary), 32'h4);
      chk($sformatf("bp:rdy%0d", c), 32'(o_ready), 32'd0);
      step();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    chk("bp:hold", 32'(o_binary), 32'h4);
    step();
    chk("bp:idle_vld", 32'(o_valid), 32'd0);
    chk("bp:idle_rdy", 32'(o_ready), 32'd1);

    // 5: reset mid-decode
    i_gray  = 4'b1101;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("mrst:vld", 32'(o_valid), 32'd0);
    chk("mrst:bin", 32'(o_binary), 32'd0);
    chk("mrst:serr", 32'(o_step_err), 32'd0);
    chk("mrst:rdy", 32'(o_ready), 32'd1);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("mrst:quiet%0d", c), 32'(o_valid), 32'd0);
    end
    xfer(4'b1101, 4'b1001, "mrst:next", e);

    // 6: step checker
    i_rst = 1'b1;
    repeat (2) step();
    i_rst = 1'b0;
    xfer(4'b0000, 4'b0000, "sc0", errs[0]);
    xfer(4'b0001, 4'b0001, "sc1", errs[1]);
    xfer(4'b0011, 4'b0010, "sc2", errs[2]);
    xfer(4'b0000, 4'b0000, "sc3", errs[3]);
    xfer(4'b0000, 4'b0000, "sc4", errs[4]);
`ifdef GRAY_STEP_CHECK_EN
    exp_errs = 5'b11000;
`else
    exp_errs = 5'b00000;
`endif
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("serr%0d", i),
          32'(errs[i]), 32'(exp_errs[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
